// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-scan 3x3 sliding window generator built from two line buffers.
// Windows are emitted one clock after the pixel that completes them; no border padding.
module window_gen_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic [7:0] p9,
    output logic       win_valid,
    output logic       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;

    // frame_start takes effect before the pixel on the same edge is positioned
    always_comb begin
        cur_col      = frame_start ? '0 : col_q;
        cur_row      = frame_start ? '0 : row_q;
        col_d        = cur_col;
        row_d        = cur_row;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (pix_valid) begin
            col_d        = (cur_col == CW'(IMG_W - 1)) ? '0 : cur_col + CW'(1);
            row_d        = (cur_col != CW'(IMG_W - 1)) ? cur_row :
                           (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
            win_d        = '{win_q[1], win_q[2], lb1[cur_col],
                             win_q[4], win_q[5], lb0[cur_col],
                             win_q[7], win_q[8], pix_in};
            win_valid_d  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            frame_done_d = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: 8'h00};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // line buffers carry no reset; rows 0 and 1 of each frame overwrite them before use
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[cur_col] <= lb0[cur_col];
            lb0[cur_col] <= pix_in;
        end
    end

    assign p1         = win_q[0];
    assign p2         = win_q[1];
    assign p3         = win_q[2];
    assign p4         = win_q[3];
    assign p5         = win_q[4];
    assign p6         = win_q[5];
    assign p7         = win_q[6];
    assign p8         = win_q[7];
    assign p9         = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 64: pixels per row, minimum 3.
REQ-002 SHALL have parameter IMG_H, default 64: rows per frame, minimum 3.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_start, input, 1 bit: synchronous restart of the row/column counters.
REQ-006 SHALL have port pix_in, input, 8 bits: raster-order pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in accepted on this edge.
REQ-008 SHALL have ports p1..p9, output, 8 bits each: 3x3 window in row-major order (p1 top-left, p9 bottom-right), registered.
REQ-009 SHALL have port win_valid, output, 1 bit: p1..p9 hold a complete window.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-011 SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1); each accepted pixel advances col; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
REQ-012 SHALL hold two line buffers of IMG_W x 8 bits: lb0 holds row r-1 and lb1 holds row r-2, both indexed by col.
REQ-013 SHALL, on each accepted pixel at column c, read top=lb1[c] and mid=lb0[c], then write lb1[c]<=lb0[c] and lb0[c]<=pix_in in the same edge.
REQ-014 SHALL shift the window one column left on each accepted pixel: p1<=p2, p2<=p3, p3<=top; p4<=p5, p5<=p6, p6<=mid; p7<=p8, p8<=p9, p9<=pix_in.
REQ-015 SHALL register win_valid=1 on the edge that accepts pixel (r,c) with r>=2 and c>=2; otherwise win_valid SHALL register 0 (latency one clock, no border padding).
REQ-016 SHALL, on a pix_valid=0 cycle, hold counters, line buffers and p1..p9 unchanged and drive win_valid=0.
REQ-017 SHALL register frame_done=1 on the edge accepting pixel (IMG_H-1, IMG_W-1), coincident with that frame's last win_valid; else frame_done=0.
REQ-018 SHALL, when frame_start=1, clear row and col to 0 and register win_valid=0 and frame_done=0 before any pixel is considered; when pix_valid=1 is also asserted, that pixel SHALL be accepted as (0,0).
REQ-019 SHALL emit exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per complete frame.
REQ-020 SHALL apply no backpressure; the downstream kernel consumes p1..p9 combinationally in the win_valid cycle.
REQ-021 SHALL pass pixel values unmodified; no arithmetic is performed on data.

Reset
REQ-022 SHALL, while rst_n=0, force row=0, col=0, p1..p9=0x00, win_valid=0 and frame_done=0 immediately and asynchronously.
REQ-023 SHALL NOT require line buffer contents to be reset; stale contents SHALL never appear under win_valid=1.
REQ-024 SHALL, on reset deasserted mid-frame, treat the next accepted pixel as (0,0).

Verification (IMG_W=4, IMG_H=4, pixel (r,c)=16*r+c)
REQ-025 SHALL cover: a continuous frame -> the first win_valid carries p1..p9 = 00,01,02,10,11,12,20,21,22; the second win_valid carries 01,02,03,11,12,13,21,22,23.
REQ-026 SHALL cover: a continuous frame -> exactly 4 win_valid pulses, and frame_done=1 only together with the window ending at 0x33.
REQ-027 SHALL cover: the same frame with random pix_valid gaps -> an identical sequence of windows, and win_valid=0 during every gap.
REQ-028 SHALL cover: rst_n low after 7 pixels, then a full frame -> no win_valid before pixel (2,2) of the new frame, and windows match REQ-025.
REQ-029 SHALL cover: frame_start after 9 pixels, then a full frame -> windows match REQ-025, with no partial window from the aborted frame.
REQ-030 SHALL cover: all pixels 0xFF, two back-to-back frames -> every window is all 0xFF, with 8 win_valid pulses and 2 frame_done pulses in total.
